time_cnt_sync_gen: RTL and testbench

Per-transducer time counter bank, the parametrised successor of the round-robin time counter generator. Each channel i free-runs a modulo-CYCLE[i] counter. An internal iterative divider walks all channels in turn and phase-corrects each counter to SYS_TIME mod CYCLE[i]. It replaces the vendor divider IP with in-block logic and adds lock status, a correction counter and safe handling of cycle changes. It sits between the system-time block and the PWM generators.

---
 rtl/time_cnt_sync_gen_if.sv | 31 +++
 rtl/time_cnt_sync_gen.sv | 149 ++++++++++++++
 tb/tb_time_cnt_sync_gen.sv | 205 ++++++++++++++++++++
 3 files changed

// File: rtl/time_cnt_sync_gen_if.sv
// Bus bundle for the per-channel time counter bank: system time and
// per-channel periods in, per-channel counters and sweep status out.
// There is no valid/ready handshake here: SYS_TIME and CYCLE are sampled
// every clock, and every output is a register that is valid every cycle.
interface time_cnt_sync_gen_if #(
    parameter int WIDTH     = 13,
    parameter int DEPTH     = 249,
    parameter int SYS_WIDTH = 64,
    parameter int CNT_WIDTH = 16,
    parameter int KW        = (DEPTH > 1) ? $clog2(DEPTH) : 1
);
    logic [SYS_WIDTH-1:0] SYS_TIME;
    logic [WIDTH-1:0]     CYCLE    [DEPTH];
    logic [WIDTH-1:0]     TIME_CNT [DEPTH];
    logic                 SWEEP_DONE;
    logic                 LOCKED;
    logic [CNT_WIDTH-1:0] CORR_CNT;
    // Debug view of the sweep FSM: state encoding and channel under visit.
    logic [1:0]           dbg_state;
    logic [KW-1:0]        dbg_chan;

    modport master (
        output SYS_TIME, CYCLE,
        input  TIME_CNT, SWEEP_DONE, LOCKED, CORR_CNT, dbg_state, dbg_chan
    );

    modport slave (
        input  SYS_TIME, CYCLE,
        output TIME_CNT, SWEEP_DONE, LOCKED, CORR_CNT, dbg_state, dbg_chan
    );
endinterface

// File: rtl/time_cnt_sync_gen.sv
// Per-channel modulo time counters. Each channel free-runs modulo its
// period; a shared bit-serial divider visits the channels round-robin and
// phase-corrects each counter to SYS_TIME mod CYCLE.
module time_cnt_sync_gen #(
    parameter int WIDTH     = 13,
    parameter int DEPTH     = 249,
    parameter int SYS_WIDTH = 64,
    parameter int CNT_WIDTH = 16
) (
    input  logic              CLK,
    input  logic              RST,
    time_cnt_sync_gen_if.slave bus
);
    localparam int KW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int BW = (SYS_WIDTH > 1) ? $clog2(SYS_WIDTH) : 1;

    typedef enum logic [1:0] {
        LOAD  = 2'd0,
        DIV   = 2'd1,
        APPLY = 2'd2
    } state_t;

    state_t               state;
    logic [KW-1:0]        k;
    logic [SYS_WIDTH-1:0] s_cap;
    logic [WIDTH-1:0]     t0;
    logic [WIDTH-1:0]     c0;
    logic [WIDTH-1:0]     rem;
    logic [BW-1:0]        bit_idx;
    logic [WIDTH-1:0]     t [DEPTH];
    logic                 sweep_done;
    logic                 locked;
    logic                 dirty;
    logic                 first_sweep;
    logic [CNT_WIDTH-1:0] corr_cnt;

    logic [WIDTH:0]       rem_shift;
    logic [WIDTH:0]       rem_next;
    logic [WIDTH-1:0]     delta;
    logic [WIDTH-1:0]     n_k;
    logic [WIDTH:0]       sum;
    logic [WIDTH-1:0]     corr_val;
    logic                 do_corr;

    // Free-run step: periods below 2 pin the counter at 0, and a counter at
    // or beyond the last value (including after the period shrank) wraps.
    function automatic logic [WIDTH-1:0] free_next(input logic [WIDTH-1:0] tv,
                                                    input logic [WIDTH-1:0] cv);
        if (cv < WIDTH'(2))
            free_next = '0;
        else if (tv >= cv - WIDTH'(1))
            free_next = '0;
        else
            free_next = tv + WIDTH'(1);
    endfunction

    // Divider step and correction arithmetic for the channel under visit.
    // The stored remainder is always below C0, so it fits WIDTH bits; the
    // shifted working value needs WIDTH+1.
    always_comb begin
        rem_shift = {rem, s_cap[bit_idx]};
        rem_next  = (rem_shift >= {1'b0, c0}) ? rem_shift - {1'b0, c0} : rem_shift;
        delta     = (rem >= t0) ? rem - t0 : rem + c0 - t0;
        n_k       = free_next(t[k], bus.CYCLE[k]);
        sum       = {1'b0, n_k} + {1'b0, delta};
        corr_val  = (sum >= {1'b0, c0}) ? sum[WIDTH-1:0] - c0 : sum[WIDTH-1:0];
        // A period changed since LOAD (or a t0 captured beyond the new
        // period) makes the captured phase meaningless; skip and let the
        // next visit repair the channel.
        do_corr   = (state == APPLY) && (c0 >= WIDTH'(2)) &&
                    (bus.CYCLE[k] == c0) && (t0 < c0) && (delta != '0);
    end

    // Counter bank: free-run every channel, override the visited channel
    // when a phase correction is due.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            for (int i = 0; i < DEPTH; i++) t[i] <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (do_corr && (k == KW'(i)))
                    t[i] <= corr_val;
                else
                    t[i] <= free_next(t[i], bus.CYCLE[i]);
            end
        end
    end

    // Sweep FSM with divider datapath and registered status outputs.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state       <= LOAD;
            k           <= '0;
            s_cap       <= '0;
            t0          <= '0;
            c0          <= '0;
            rem         <= '0;
            bit_idx     <= '0;
            sweep_done  <= 1'b0;
            locked      <= 1'b0;
            dirty       <= 1'b0;
            first_sweep <= 1'b1;
            corr_cnt    <= '0;
        end else begin
            sweep_done <= 1'b0;
            case (state)
                LOAD: begin
                    s_cap   <= bus.SYS_TIME;
                    t0      <= t[k];
                    c0      <= bus.CYCLE[k];
                    rem     <= '0;
                    bit_idx <= BW'(SYS_WIDTH - 1);
                    if (k == '0) dirty <= 1'b0;
                    state   <= DIV;
                end
                DIV: begin
                    rem <= rem_next[WIDTH-1:0];
                    if (bit_idx == '0)
                        state <= APPLY;
                    else
                        bit_idx <= bit_idx - BW'(1);
                end
                APPLY: begin
                    if (do_corr) begin
                        dirty <= 1'b1;
                        if (corr_cnt != '1) corr_cnt <= corr_cnt + CNT_WIDTH'(1);
                    end
                    if (k == KW'(DEPTH - 1)) begin
                        sweep_done  <= 1'b1;
                        locked      <= !first_sweep && !(dirty || do_corr);
                        first_sweep <= 1'b0;
                        k           <= '0;
                    end else begin
                        k <= k + KW'(1);
                    end
                    state <= LOAD;
                end
                default: state <= LOAD;
            endcase
        end
    end

    assign bus.TIME_CNT   = t;
    assign bus.SWEEP_DONE = sweep_done;
    assign bus.LOCKED     = locked;
    assign bus.CORR_CNT   = corr_cnt;
    assign bus.dbg_state  = state;
    assign bus.dbg_chan   = k;
endmodule

// File: tb/tb_time_cnt_sync_gen.sv
// Directed bench for time_cnt_sync_gen with DEPTH=4, SYS_WIDTH=16
// (72-cycle sweep). Alignment is judged against SYS_TIME mod CYCLE.
module tb_time_cnt_sync_gen;
  localparam int WIDTH     = 13;
  localparam int DEPTH     = 4;
  localparam int SYS_WIDTH = 16;
  localparam int CNT_WIDTH = 16;
  localparam int SWEEP     = 72;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int total = 0;
  int bad = 0;
  int cyc = 0;
  int sweep_seen = 0;
  int last_sweep = -1;

  time_cnt_sync_gen_if #(.WIDTH(WIDTH), .DEPTH(DEPTH), .SYS_WIDTH(SYS_WIDTH),
                         .CNT_WIDTH(CNT_WIDTH)) bus ();

  time_cnt_sync_gen #(.WIDTH(WIDTH), .DEPTH(DEPTH), .SYS_WIDTH(SYS_WIDTH),
                      .CNT_WIDTH(CNT_WIDTH)) dut (
    .CLK (clk),
    .RST (rst),
    .bus (bus)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", tag, obs, exp);
    end
  endtask

  // driver: one clock; outputs sampled 1 time unit after the edge
  task automatic tick();
    @(posedge clk);
    #1;
    bus.SYS_TIME = bus.SYS_TIME + 16'd1;
    cyc++;
    if (bus.SWEEP_DONE) begin
      sweep_seen++;
      last_sweep = cyc;
    end
  endtask

  function automatic int misaligned();
    int e = 0;
    for (int ch = 0; ch < DEPTH; ch++) begin
      int exp_v;
      if (int'(bus.CYCLE[ch]) < 2) exp_v = 0;
      else exp_v = int'(bus.SYS_TIME) % int'(bus.CYCLE[ch]);
      if (int'(bus.TIME_CNT[ch]) != exp_v) e++;
    end
    return e;
  endfunction

  function automatic int cnt_or();
    int v = 0;
    for (int ch = 0; ch < DEPTH; ch++) v = v | int'(bus.TIME_CNT[ch]);
    return v;
  endfunction

  task automatic run_aligned(input int n, input string tag);
    int errs = 0;
    repeat (n) begin
      tick();
      errs += misaligned();
    end
    check(tag, errs, 0);
  endtask

  task automatic release_reset(input logic [15:0] s0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    bus.SYS_TIME = s0;
    cyc = 0;
    sweep_seen = 0;
    last_sweep = -1;
  endtask

  // All CYCLE = 100, SYS_TIME from 1003: every channel starts 3 behind.
  task automatic startup(input string tag);
    repeat (SWEEP - 1) tick();
    check({tag, "_no_early_sweep"}, sweep_seen, 0);
    tick();
    check({tag, "_sweep1_cycle"}, last_sweep, 72);
    check({tag, "_corr_after_sweep1"}, bus.CORR_CNT, 4);
    check({tag, "_unlocked_sweep1"}, bus.LOCKED, 0);
    check({tag, "_aligned_at_72"}, misaligned(), 0);
    run_aligned(SWEEP - 1, {tag, "_aligned_73_143"});
    check({tag, "_single_pulse"}, sweep_seen, 1);
    tick();
    check({tag, "_sweep2_cycle"}, last_sweep, 144);
    check({tag, "_locked_sweep2"}, bus.LOCKED, 1);
    check({tag, "_corr_after_sweep2"}, bus.CORR_CNT, 4);
    check({tag, "_aligned_at_144"}, misaligned(), 0);
  endtask

  initial begin
    int found;
    int corr_before;
    bus.SYS_TIME = 16'd1003;
    for (int ch = 0; ch < DEPTH; ch++) bus.CYCLE[ch] = 13'd100;

    // reset state
    repeat (2) @(posedge clk);
    #1;
    check("reset_time_cnt", cnt_or(), 0);
    check("reset_sweep_done", bus.SWEEP_DONE, 0);
    check("reset_locked", bus.LOCKED, 0);
    check("reset_corr_cnt", bus.CORR_CNT, 0);
    check("reset_state", bus.dbg_state, 0);
    check("reset_chan", bus.dbg_chan, 0);

    // startup lock
    release_reset(16'd1003);
    startup("start");

    // time jump right after a sweep boundary: every channel goes 37 off
    bus.SYS_TIME = bus.SYS_TIME + 16'd37;
    check("jump_all_off", misaligned(), DEPTH);
    repeat (SWEEP - 1) tick();
    tick();
    check("jump_sweep_cycle", last_sweep, 216);
    check("jump_unlocked", bus.LOCKED, 0);
    check("jump_corr", bus.CORR_CNT, 8);
    check("jump_realigned", misaligned(), 0);
    run_aligned(SWEEP, "jump_aligned_next_sweep");
    check("jump_relock_cycle", last_sweep, 288);
    check("jump_relocked", bus.LOCKED, 1);

    // cycle shrink on channel 1 while its counter reads 90
    found = 0;
    for (int i = 0; i < 100 && found == 0; i++) begin
      if (bus.TIME_CNT[1] == 13'd90) found = 1;
      else tick();
    end
    check("shrink_find_90", found, 1);
    corr_before = int'(bus.CORR_CNT);
    bus.CYCLE[1] = 13'd50;
    tick();
    check("shrink_wrap_zero", bus.TIME_CNT[1], 0);
    repeat (2 * SWEEP) tick();
    run_aligned(SWEEP, "shrink_aligned");
    check("shrink_one_corr", int'(bus.CORR_CNT) - corr_before, 1);

    // degenerate periods on channel 2
    corr_before = int'(bus.CORR_CNT);
    bus.CYCLE[2] = 13'd0;
    run_aligned(100, "degen_cycle0");
    bus.CYCLE[2] = 13'd1;
    run_aligned(100, "degen_cycle1");
    check("degen_no_corr", int'(bus.CORR_CNT) - corr_before, 0);

    // async reset in the middle of channel 1's division
    for (int ch = 0; ch < DEPTH; ch++) bus.CYCLE[ch] = 13'd100;
    rst = 1'b1;
    release_reset(16'd1003);
    repeat (30) tick();
    check("middiv_corr_before", bus.CORR_CNT, 1);
    check("middiv_in_div", bus.dbg_state, 1);
    check("middiv_chan", bus.dbg_chan, 1);
    #1;
    rst = 1'b1;
    #1;
    check("middiv_time_cnt_zero", cnt_or(), 0);
    check("middiv_corr_zero", bus.CORR_CNT, 0);
    check("middiv_locked_zero", bus.LOCKED, 0);
    check("middiv_state_load", bus.dbg_state, 0);
    check("middiv_chan_zero", bus.dbg_chan, 0);
    repeat (2) @(posedge clk);
    release_reset(16'd1003);
    startup("rerun");

    // mixed periods from SYS_TIME 40000: channel 0 already in phase,
    // channels 1..3 each need one correction
    bus.CYCLE[0] = 13'd2;
    bus.CYCLE[1] = 13'd7;
    bus.CYCLE[2] = 13'd4096;
    bus.CYCLE[3] = 13'd8191;
    rst = 1'b1;
    release_reset(16'd40000);
    repeat (SWEEP) tick();
    check("mixed_corr_sweep1", bus.CORR_CNT, 3);
    check("mixed_aligned_at_72", misaligned(), 0);
    run_aligned(1000, "mixed_aligned_1000");
    check("mixed_corr_stable", bus.CORR_CNT, 3);
    check("mixed_locked", bus.LOCKED, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
